// File: rtl/soc_ahb3_ext_arbiter.sv
// Round-robin arbiter sharing one AHB3-Lite slave among NODES tile masters.
// Optional data-phase timeout is enabled by defining MPSOC_AHB3_ARB_TIMEOUT_EN.
module soc_ahb3_ext_arbiter #(
  parameter int NODES   = 16,
  parameter int PLEN    = 32,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NODES-1:0]                mst_hsel,
  input  logic [NODES-1:0][PLEN-1:0]      mst_haddr,
  input  logic [NODES-1:0][XLEN-1:0]      mst_hwdata,
  input  logic [NODES-1:0]                mst_hwrite,
  input  logic [NODES-1:0][2:0]           mst_hsize,
  input  logic [NODES-1:0][2:0]           mst_hburst,
  input  logic [NODES-1:0][3:0]           mst_hprot,
  input  logic [NODES-1:0][1:0]           mst_htrans,
  input  logic [NODES-1:0]                mst_hmastlock,
  output logic [NODES-1:0][XLEN-1:0]      mst_hrdata,
  output logic [NODES-1:0]                mst_hready,
  output logic [NODES-1:0]                mst_hresp,
  output logic                            slv_hsel,
  output logic [PLEN-1:0]                 slv_haddr,
  output logic [XLEN-1:0]                 slv_hwdata,
  output logic                            slv_hwrite,
  output logic [2:0]                      slv_hsize,
  output logic [2:0]                      slv_hburst,
  output logic [3:0]                      slv_hprot,
  output logic [1:0]                      slv_htrans,
  output logic                            slv_hmastlock,
  input  logic [XLEN-1:0]                 slv_hrdata,
  input  logic                            slv_hready,
  input  logic                            slv_hresp,
  output logic [$clog2(NODES)-1:0]        grant,
  output logic                            grant_vld,
  output logic                            timeout
);

  localparam int         IW         = $clog2(NODES);
  localparam logic [1:0] HT_IDLE    = 2'b00;
  localparam logic [1:0] HT_NONSEQ  = 2'b10;

  logic [NODES-1:0] req;
  logic [IW-1:0]    a_owner, d_owner, rr_ptr, winner, rr_next;
  logic             a_vld, d_vld, found, fire, owner_cont, owner_lock, addr_on;
  logic             force_idle;
  int               idx;

`ifdef MPSOC_AHB3_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {ST_NORM, ST_ERR1, ST_ERR2, ST_DRAIN} to_st_e;
  to_st_e        to_st;
  logic [TW-1:0] to_cnt;
  logic          err_act;
  assign force_idle = (to_st != ST_NORM);
  assign err_act    = (to_st == ST_ERR1) || (to_st == ST_ERR2);
`else
  assign force_idle = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    for (int m = 0; m < NODES; m++)
      req[m] = mst_hsel[m] && (mst_htrans[m] == HT_NONSEQ);
  end

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NODES; i++) begin
      idx = (int'(rr_ptr) + i) % NODES;
      if (!found && req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign rr_next    = (winner == IW'(NODES - 1)) ? '0 : winner + 1'b1;
  assign owner_cont = a_vld && mst_hsel[a_owner] && (mst_htrans[a_owner] != HT_IDLE);
  assign owner_lock = a_vld && mst_hmastlock[a_owner];
  assign fire       = slv_hready && !owner_cont && !owner_lock && (|req) && !force_idle;
  assign addr_on    = a_vld && !force_idle;
  assign grant      = a_owner;
  assign grant_vld  = a_vld;

  always_comb begin
    slv_hsel      = 1'b0;
    slv_haddr     = '0;
    slv_hwrite    = 1'b0;
    slv_hsize     = '0;
    slv_hburst    = '0;
    slv_hprot     = '0;
    slv_htrans    = HT_IDLE;
    slv_hmastlock = 1'b0;
    if (addr_on) begin
      slv_hsel      = mst_hsel[a_owner];
      slv_haddr     = mst_haddr[a_owner];
      slv_hwrite    = mst_hwrite[a_owner];
      slv_hsize     = mst_hsize[a_owner];
      slv_hburst    = mst_hburst[a_owner];
      slv_hprot     = mst_hprot[a_owner];
      slv_htrans    = mst_htrans[a_owner];
      slv_hmastlock = mst_hmastlock[a_owner];
    end
  end

  assign slv_hwdata = mst_hwdata[d_owner];

  // Non-owner requesters are held in their address phase.
  always_comb begin
    for (int m = 0; m < NODES; m++) begin
      mst_hrdata[m] = slv_hrdata;
      mst_hresp[m]  = d_vld && (d_owner == IW'(m)) && slv_hresp;
      mst_hready[m] = (a_vld && (a_owner == IW'(m))) ? slv_hready : !req[m];
`ifdef MPSOC_AHB3_ARB_TIMEOUT_EN
      if (err_act && (d_owner == IW'(m))) begin
        mst_hresp[m]  = 1'b1;
        mst_hready[m] = (to_st == ST_ERR2);
      end else if (force_idle && a_vld && (a_owner == IW'(m))) begin
        mst_hready[m] = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_owner <= '0;
      a_vld   <= 1'b0;
      d_owner <= '0;
      d_vld   <= 1'b0;
      rr_ptr  <= '0;
`ifdef MPSOC_AHB3_ARB_TIMEOUT_EN
      to_st   <= ST_NORM;
      to_cnt  <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      if (fire) begin
        a_owner <= winner;
        a_vld   <= 1'b1;
        rr_ptr  <= rr_next;
      end
      if (slv_hready && !force_idle) begin
        d_vld   <= addr_on && mst_hsel[a_owner] && mst_htrans[a_owner][1];
        d_owner <= a_owner;
      end
`ifdef MPSOC_AHB3_ARB_TIMEOUT_EN
      case (to_st)
        ST_NORM: begin
          if (d_vld && !slv_hready) begin
            if (to_cnt == TW'(TIMEOUT - 1)) begin
              to_st   <= ST_ERR1;
              to_cnt  <= '0;
              d_vld   <= 1'b0;
              timeout <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end else begin
            to_cnt <= '0;
          end
        end
        ST_ERR1:  to_st <= ST_ERR2;
        ST_ERR2:  to_st <= ST_DRAIN;
        default:  if (slv_hready) to_st <= ST_NORM;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_soc_ahb3_ext_arbiter.sv
// Directed bench for soc_ahb3_ext_arbiter: table-driven handover vectors plus
// hand-written burst, lock, error-response, reset and timeout sequences.
module tb_soc_ahb3_ext_arbiter;
  localparam int NODES = 16, PLEN = 32, XLEN = 32, TIMEOUT = 8;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NODES-1:0]           mst_hsel, mst_hwrite, mst_hmastlock;
  logic [NODES-1:0][PLEN-1:0] mst_haddr;
  logic [NODES-1:0][XLEN-1:0] mst_hwdata, mst_hrdata;
  logic [NODES-1:0][2:0]      mst_hsize, mst_hburst;
  logic [NODES-1:0][3:0]      mst_hprot;
  logic [NODES-1:0][1:0]      mst_htrans;
  logic [NODES-1:0]           mst_hready, mst_hresp;
  logic                       slv_hsel, slv_hwrite, slv_hmastlock;
  logic [PLEN-1:0]            slv_haddr;
  logic [XLEN-1:0]            slv_hwdata, slv_hrdata;
  logic [2:0]                 slv_hsize, slv_hburst;
  logic [3:0]                 slv_hprot;
  logic [1:0]                 slv_htrans;
  logic                       slv_hready, slv_hresp;
  logic [$clog2(NODES)-1:0]   grant;
  logic                       grant_vld, timeout;

  soc_ahb3_ext_arbiter #(.NODES(NODES), .PLEN(PLEN), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mst_hsel(mst_hsel), .mst_haddr(mst_haddr), .mst_hwdata(mst_hwdata),
    .mst_hwrite(mst_hwrite), .mst_hsize(mst_hsize), .mst_hburst(mst_hburst),
    .mst_hprot(mst_hprot), .mst_htrans(mst_htrans), .mst_hmastlock(mst_hmastlock),
    .mst_hrdata(mst_hrdata), .mst_hready(mst_hready), .mst_hresp(mst_hresp),
    .slv_hsel(slv_hsel), .slv_haddr(slv_haddr), .slv_hwdata(slv_hwdata),
    .slv_hwrite(slv_hwrite), .slv_hsize(slv_hsize), .slv_hburst(slv_hburst),
    .slv_hprot(slv_hprot), .slv_htrans(slv_htrans), .slv_hmastlock(slv_hmastlock),
    .slv_hrdata(slv_hrdata), .slv_hready(slv_hready), .slv_hresp(slv_hresp),
    .grant(grant), .grant_vld(grant_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  typedef struct {
    logic [NODES-1:0] sel;
    logic [NODES-1:0] ns;
    logic [3:0]       eg;
    logic             egv;
    logic [1:0]       et;
    logic [NODES-1:0] erdy;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [31:0] addr_of(input int m);
    return 32'h4000_0000 + 32'(m) * 32'h100;
  endfunction

  task automatic clr();
    mst_hsel = '0; mst_haddr = '0; mst_hwdata = '0; mst_hwrite = '0; mst_hsize = '0;
    mst_hburst = '0; mst_hprot = '0; mst_htrans = '0; mst_hmastlock = '0;
    slv_hrdata = '0; slv_hready = 1'b1; slv_hresp = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a,
                     input logic wr, input logic [2:0] bu, input logic lk);
    mst_hsel[m] = 1'b1; mst_htrans[m] = tr; mst_haddr[m] = a; mst_hwrite[m] = wr;
    mst_hburst[m] = bu; mst_hmastlock[m] = lk; mst_hsize[m] = 3'd2;
  endtask

  initial begin
    // tiles 0,5,9 at once, then 9 vs 2 with 9 still owning
    tbl[0]  = '{16'h0221, 16'h0221, 4'd0, 1'b0, IDLE,   16'hFDDE};
    tbl[1]  = '{16'h0221, 16'h0221, 4'd0, 1'b1, NONSEQ, 16'hFDDF};
    tbl[2]  = '{16'h0221, 16'h0220, 4'd0, 1'b1, IDLE,   16'hFDDF};
    tbl[3]  = '{16'h0221, 16'h0220, 4'd5, 1'b1, NONSEQ, 16'hFDFF};
    tbl[4]  = '{16'h0221, 16'h0200, 4'd5, 1'b1, IDLE,   16'hFDFF};
    tbl[5]  = '{16'h0200, 16'h0200, 4'd9, 1'b1, NONSEQ, 16'hFFFF};
    tbl[6]  = '{16'h0000, 16'h0000, 4'd9, 1'b1, IDLE,   16'hFFFF};
    tbl[7]  = '{16'h0204, 16'h0204, 4'd9, 1'b1, NONSEQ, 16'hFFFB};
    tbl[8]  = '{16'h0204, 16'h0004, 4'd9, 1'b1, IDLE,   16'hFFFB};
    tbl[9]  = '{16'h0004, 16'h0004, 4'd2, 1'b1, NONSEQ, 16'hFFFF};
    tbl[10] = '{16'h0000, 16'h0000, 4'd2, 1'b1, IDLE,   16'hFFFF};

    do_reset(); settle();
    chk("rst_htrans", slv_htrans, IDLE);
    chk("rst_hsel", slv_hsel, 0);
    chk("rst_haddr", slv_haddr, 0);
    chk("rst_grant", grant, 0);
    chk("rst_gvld", grant_vld, 0);
    chk("rst_hready", mst_hready, 16'hFFFF);
    chk("rst_hresp", mst_hresp, 0);
    chk("rst_timeout", timeout, 0);

    for (int i = 0; i < 11; i++) begin
      cyc();
      for (int m = 0; m < NODES; m++) begin
        mst_hsel[m]   = tbl[i].sel[m];
        mst_htrans[m] = tbl[i].ns[m] ? NONSEQ : IDLE;
        mst_haddr[m]  = addr_of(m);
      end
      settle();
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].eg);
      chk($sformatf("tbl%0d_gvld", i), grant_vld, tbl[i].egv);
      chk($sformatf("tbl%0d_htrans", i), slv_htrans, tbl[i].et);
      chk($sformatf("tbl%0d_hready", i), mst_hready, tbl[i].erdy);
      if (tbl[i].et == NONSEQ) chk($sformatf("tbl%0d_haddr", i), slv_haddr, addr_of(int'(tbl[i].eg)));
    end

    // tile 3 single write
    do_reset();
    cyc(); drv(3, NONSEQ, 32'h1000, 1'b1, 3'd0, 1'b0); settle();
    chk("w3_stall", mst_hready[3], 0);
    chk("w3_gvld0", grant_vld, 0);
    cyc(); settle();
    chk("w3_grant", grant, 3);
    chk("w3_haddr", slv_haddr, 32'h1000);
    chk("w3_hwrite", slv_hwrite, 1);
    chk("w3_rdy", mst_hready[3], 1);
    cyc(); mst_htrans[3] = IDLE; mst_hwdata[3] = 32'hDEADBEEF; slv_hready = 1'b0; settle();
    chk("w3_hwdata", slv_hwdata, 32'hDEADBEEF);
    chk("w3_rdy_wait", mst_hready[3], 0);
    cyc(); slv_hready = 1'b1; settle();
    chk("w3_rdy_done", mst_hready[3], 1);
    chk("w3_hresp", mst_hresp, 0);

    // tile 2 INCR4 against tile 7, then locked sequence from tile 7
    do_reset();
    cyc(); drv(2, NONSEQ, 32'h200, 1'b1, 3'b011, 1'b0); drv(7, NONSEQ, 32'h700, 1'b0, 3'd0, 1'b0); settle();
    chk("b_stall7", mst_hready[7], 0);
    cyc(); settle();
    chk("b_grant2", grant, 2);
    chk("b_hburst", slv_hburst, 3'b011);
    chk("b_haddr", slv_haddr, 32'h200);
    for (int k = 1; k < 4; k++) begin
      cyc(); drv(2, SEQ, 32'h200 + 32'(k) * 4, 1'b1, 3'b011, 1'b0); settle();
      chk($sformatf("b_beat%0d_grant", k), grant, 2);
      chk($sformatf("b_beat%0d_htrans", k), slv_htrans, SEQ);
      chk($sformatf("b_beat%0d_stall7", k), mst_hready[7], 0);
    end
    cyc(); mst_htrans[2] = IDLE; settle();
    chk("b_idle_grant", grant, 2);
    chk("b_idle_htrans", slv_htrans, IDLE);
    cyc(); drv(7, NONSEQ, 32'h700, 1'b0, 3'd0, 1'b1); drv(2, NONSEQ, 32'h220, 1'b0, 3'd0, 1'b0); settle();
    chk("l_grant7", grant, 7);
    chk("l_lock", slv_hmastlock, 1);
    chk("l_stall2", mst_hready[2], 0);
    cyc(); mst_htrans[7] = IDLE; settle();
    cyc(); settle();
    chk("l_hold1", grant, 7);
    chk("l_stall2b", mst_hready[2], 0);
    cyc(); mst_hmastlock[7] = 1'b0; settle();
    chk("l_hold2", grant, 7);
    cyc(); settle();
    chk("l_grant2", grant, 2);
    chk("l_htrans2", slv_htrans, NONSEQ);

    // tile 4 read: 3 wait states then ERROR, tile 6 waiting
    do_reset();
    cyc(); drv(4, NONSEQ, 32'h400, 1'b0, 3'd0, 1'b0); drv(6, NONSEQ, 32'h600, 1'b0, 3'd0, 1'b0); settle();
    cyc(); settle();
    chk("r_grant4", grant, 4);
    for (int k = 0; k < 3; k++) begin
      cyc(); mst_htrans[4] = IDLE; slv_hready = 1'b0; settle();
      chk($sformatf("r_wait%0d_rdy4", k), mst_hready[4], 0);
      chk($sformatf("r_wait%0d_rdy6", k), mst_hready[6], 0);
      chk($sformatf("r_wait%0d_hresp", k), mst_hresp, 0);
    end
    cyc(); slv_hresp = 1'b1; settle();
    chk("r_err1_hresp", mst_hresp, 16'h0010);
    chk("r_err1_rdy4", mst_hready[4], 0);
    cyc(); slv_hready = 1'b1; slv_hrdata = 32'hCAFEF00D; settle();
    chk("r_err2_hresp", mst_hresp, 16'h0010);
    chk("r_err2_rdy4", mst_hready[4], 1);
    chk("r_hrdata4", mst_hrdata[4], 32'hCAFEF00D);
    cyc(); slv_hresp = 1'b0; settle();
    chk("r_grant6", grant, 6);
    chk("r_hresp_clr", mst_hresp, 0);

    // asynchronous reset in the middle of a burst
    do_reset();
    cyc(); drv(5, NONSEQ, 32'h500, 1'b1, 3'b011, 1'b0); settle();
    cyc(); settle();
    chk("ar_grant5", grant, 5);
    cyc(); mst_htrans[5] = SEQ; #1 rst_n = 1'b0; #1;
    chk("ar_gvld", grant_vld, 0);
    chk("ar_grant", grant, 0);
    chk("ar_htrans", slv_htrans, IDLE);
    chk("ar_hready", mst_hready, 16'hFFFF);

    // tile 1 data phase with slave stuck not-ready
    do_reset();
    cyc(); drv(1, NONSEQ, 32'h100, 1'b1, 3'd0, 1'b0); settle();
    cyc(); settle();
    chk("t_grant1", grant, 1);
`ifdef MPSOC_AHB3_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      cyc(); mst_htrans[1] = IDLE; slv_hready = 1'b0; settle();
    end
    chk("t_pre_hresp", mst_hresp[1], 0);
    chk("t_pre_timeout", timeout, 0);
    cyc(); settle();
    chk("t_err1_hresp", mst_hresp[1], 1);
    chk("t_err1_rdy", mst_hready[1], 0);
    chk("t_flag", timeout, 1);
    cyc(); settle();
    chk("t_err2_hresp", mst_hresp[1], 1);
    chk("t_err2_rdy", mst_hready[1], 1);
    cyc(); settle();
    chk("t_drain_hresp", mst_hresp[1], 0);
    chk("t_drain_htrans", slv_htrans, IDLE);
    cyc(); slv_hready = 1'b1; settle();
    chk("t_drain_rdy", mst_hready[1], 0);
    cyc(); settle();
    chk("t_norm_rdy", mst_hready[1], 1);
    chk("t_sticky", timeout, 1);
`else
    for (int k = 0; k < 12; k++) begin
      cyc(); mst_htrans[1] = IDLE; slv_hready = 1'b0; settle();
    end
    chk("t_stall_rdy", mst_hready[1], 0);
    chk("t_stall_hresp", mst_hresp[1], 0);
    chk("t_no_timeout", timeout, 0);
    cyc(); slv_hready = 1'b1; settle();
    chk("t_release_rdy", mst_hready[1], 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
